stopwatch_counter: RTL and testbench

Timekeeping stage that consumes the divided clock level produced by the clock divider. It runs in the `clk_in` domain and edge-detects `tick_lvl` instead of clocking on it. It prescales the edges into seconds and maintains an MM:SS stopwatch value as four BCD digits. It supports run/pause and a manual adjust mode that steps the selected field at a faster rate.

---
 rtl/stopwatch_counter.sv | 128 ++++++++++++
 tb/tb_stopwatch_counter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_counter.sv
// rtl/stopwatch_counter.sv - MM:SS BCD stopwatch paced by rising edges of tick_lvl
// Run/pause control plus an adjust mode that steps one field at a faster rate.
module stopwatch_counter #(
  parameter int TICKS_PER_SEC = 3571429,
  parameter int TICKS_PER_ADJ = 1785714
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick_lvl,
  input  logic       pause_btn,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       step_pulse
);

  localparam int TICKS_MAX = (TICKS_PER_SEC > TICKS_PER_ADJ) ? TICKS_PER_SEC : TICKS_PER_ADJ;
  localparam int PRE_W = (TICKS_MAX > 1) ? $clog2(TICKS_MAX) : 1;
  localparam logic [PRE_W-1:0] SEC_LAST = PRE_W'(TICKS_PER_SEC - 1);
  localparam logic [PRE_W-1:0] ADJ_LAST = PRE_W'(TICKS_PER_ADJ - 1);

  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } run_state_t;

  run_state_t       state_q;
  run_state_t       state_nxt;
  logic             tick_d;
  logic             adj_d;
  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_nxt;
  logic [PRE_W-1:0] pre_last;
  logic             rise;
  logic             mode_chg;
  logic             count_en;
  logic             step;
  logic             sec_adv;
  logic             min_adv;
  logic [3:0]       so_nxt;
  logic [3:0]       st_nxt;
  logic [3:0]       mo_nxt;
  logic [3:0]       mt_nxt;

  assign rise     = tick_lvl & ~tick_d;
  assign mode_chg = adj ^ adj_d;
  assign count_en = adj | (state_q == RUN);
  assign pre_last = adj ? ADJ_LAST : SEC_LAST;
  assign running  = (state_q == RUN);

  // The enable above uses the pre-toggle state, so a rise coinciding with pause still counts.
  always_comb begin
    state_nxt = state_q;
    if (pause_btn) begin
      state_nxt = (state_q == RUN) ? PAUSED : RUN;
    end
  end

  always_comb begin
    pre_nxt = pre_q;
    step    = 1'b0;
    if (mode_chg) begin
      pre_nxt = '0;
    end else if (rise && count_en) begin
      if (pre_q == pre_last) begin
        pre_nxt = '0;
        step    = 1'b1;
      end else begin
        pre_nxt = pre_q + PRE_W'(1);
      end
    end
  end

  // Adjust steps touch only the selected field; normal steps cascade seconds into minutes.
  always_comb begin
    so_nxt  = sec_ones;
    st_nxt  = sec_tens;
    mo_nxt  = min_ones;
    mt_nxt  = min_tens;
    sec_adv = step && (!adj || sel);
    min_adv = step && (adj ? !sel : (sec_ones == 4'd9 && sec_tens == 4'd5));
    if (sec_adv) begin
      if (sec_ones == 4'd9) begin
        so_nxt = 4'd0;
        st_nxt = (sec_tens == 4'd5) ? 4'd0 : sec_tens + 4'd1;
      end else begin
        so_nxt = sec_ones + 4'd1;
      end
    end
    if (min_adv) begin
      if (min_ones == 4'd9) begin
        mo_nxt = 4'd0;
        mt_nxt = (min_tens == 4'd5) ? 4'd0 : min_tens + 4'd1;
      end else begin
        mo_nxt = min_ones + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= RUN;
      tick_d     <= 1'b0;
      adj_d      <= 1'b0;
      pre_q      <= '0;
      min_tens   <= 4'd0;
      min_ones   <= 4'd0;
      sec_tens   <= 4'd0;
      sec_ones   <= 4'd0;
      step_pulse <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      tick_d     <= tick_lvl;
      adj_d      <= adj;
      pre_q      <= pre_nxt;
      min_tens   <= mt_nxt;
      min_ones   <= mo_nxt;
      sec_tens   <= st_nxt;
      sec_ones   <= so_nxt;
      step_pulse <= step;
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// tb/tb_stopwatch_counter.sv - randomized bench for stopwatch_counter against a minutes/seconds model
module tb_stopwatch_counter;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        tick_lvl;
  logic        pause_btn;
  logic        adj;
  logic        sel;
  logic [3:0]  min_tens;
  logic [3:0]  min_ones;
  logic [3:0]  sec_tens;
  logic [3:0]  sec_ones;
  logic        running;
  logic        step_pulse;
  logic [15:0] disp;

  int checks   = 0;
  int failures = 0;
  int phase    = 0;
  int rises    = 0;
  bit rand_tick = 1'b0;

  int m_min;
  int m_sec;
  int m_pre;
  bit m_running;
  bit m_tick_d;
  bit m_adj_d;
  bit m_step;

  always #5 clk_in = ~clk_in;

  assign disp = {min_tens, min_ones, sec_tens, sec_ones};

  stopwatch_counter #(
    .TICKS_PER_SEC(4),
    .TICKS_PER_ADJ(2)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .tick_lvl  (tick_lvl),
    .pause_btn (pause_btn),
    .adj       (adj),
    .sel       (sel),
    .min_tens  (min_tens),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .running   (running),
    .step_pulse(step_pulse)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] model_disp();
    return 16'((m_min / 10) * 4096 + (m_min % 10) * 256 + (m_sec / 10) * 16 + (m_sec % 10));
  endfunction

  // Predicts the state after the coming edge from the inputs now being driven.
  task automatic model_step();
    bit r;
    bit stp;
    int lim;
    if (rst) begin
      m_min = 0; m_sec = 0; m_pre = 0;
      m_running = 1'b1; m_tick_d = 1'b0; m_adj_d = 1'b0; m_step = 1'b0;
    end else begin
      r   = tick_lvl && !m_tick_d;
      stp = 1'b0;
      lim = adj ? 2 : 4;
      if (r) rises++;
      if (adj != m_adj_d) begin
        m_pre = 0;
      end else if (r && (adj || m_running)) begin
        m_pre++;
        if (m_pre == lim) begin
          m_pre = 0;
          stp = 1'b1;
        end
      end
      if (stp) begin
        if (!adj) begin
          m_sec++;
          if (m_sec == 60) begin
            m_sec = 0;
            m_min = (m_min + 1) % 60;
          end
        end else if (sel) begin
          m_sec = (m_sec + 1) % 60;
        end else begin
          m_min = (m_min + 1) % 60;
        end
      end
      m_step = stp;
      if (pause_btn) m_running = !m_running;
      m_tick_d = tick_lvl;
      m_adj_d  = adj;
    end
  endtask

  task automatic drive_tick();
    if (rand_tick) tick_lvl = 1'($urandom_range(0, 1));
    else tick_lvl = (phase >= 14);
    phase = (phase + 1) % 28;
  endtask

  task automatic clock_edge();
    logic bcd_ok;
    model_step();
    @(posedge clk_in);
    #1;
    bcd_ok = (min_tens <= 4'd5) && (min_ones <= 4'd9) && (sec_tens <= 4'd5) && (sec_ones <= 4'd9);
    check("display", 32'(disp), 32'(model_disp()));
    check("running", 32'(running), 32'(m_running));
    check("step_pulse", 32'(step_pulse), 32'(m_step));
    check("bcd_range", 32'(bcd_ok), 32'd1);
  endtask

  task automatic do_cycle();
    drive_tick();
    clock_edge();
  endtask

  task automatic align();
    while (phase != 0) do_cycle();
  endtask

  task automatic run_rises(input int n, input bit pause_last);
    int target;
    int budget;
    target = rises + n;
    budget = n * 28 + 56;
    while (rises < target && budget > 0) begin
      drive_tick();
      if (pause_last && rises == target - 1 && tick_lvl && !m_tick_d) pause_btn = 1'b1;
      clock_edge();
      pause_btn = 1'b0;
      budget--;
    end
    check("rise_budget", 32'(rises >= target), 32'd1);
  endtask

  task automatic adj_to(input bit s, input int value);
    int budget;
    adj    = 1'b1;
    sel    = s;
    budget = 60 * 2 * 28 + 100;
    while (((s ? m_sec : m_min) != value) && budget > 0) begin
      do_cycle();
      budget--;
    end
    check("adj_budget", 32'(budget > 0), 32'd1);
  endtask

  task automatic pulse_rst();
    align();
    rst = 1'b1;
    do_cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick_lvl = 1'b0; pause_btn = 1'b0; adj = 1'b0; sel = 1'b0;
    do_cycle();
    do_cycle();
    check("rst_disp", 32'(disp), 32'h0000);
    check("rst_running", 32'(running), 32'd1);
    check("rst_step", 32'(step_pulse), 32'd0);
    rst = 1'b0;

    run_rises(4, 1'b0);
    check("count_disp", 32'(disp), 32'h0001);
    check("count_pulse", 32'(step_pulse), 32'd1);
    do_cycle();
    check("count_pulse_end", 32'(step_pulse), 32'd0);

    pulse_rst();
    run_rises(4, 1'b1);
    check("pause_disp", 32'(disp), 32'h0001);
    check("pause_running", 32'(running), 32'd0);
    run_rises(40, 1'b0);
    check("paused_hold", 32'(disp), 32'h0001);
    align();
    pause_btn = 1'b1;
    do_cycle();
    pause_btn = 1'b0;
    check("resume_running", 32'(running), 32'd1);
    run_rises(4, 1'b0);
    check("resume_disp", 32'(disp), 32'h0002);

    pulse_rst();
    adj_to(1'b1, 58);
    align();
    adj = 1'b0;
    do_cycle();
    run_rises(1, 1'b0);
    align();
    adj = 1'b1;
    sel = 1'b1;
    do_cycle();
    run_rises(1, 1'b0);
    check("adj_entry_clear", 32'(disp), 32'h0058);
    run_rises(1, 1'b0);
    check("adj_sec_59", 32'(disp), 32'h0059);
    run_rises(2, 1'b0);
    check("adj_sec_00", 32'(disp), 32'h0000);
    run_rises(2, 1'b0);
    check("adj_sec_01", 32'(disp), 32'h0001);

    adj_to(1'b0, 59);
    adj_to(1'b1, 58);
    check("preload_5958", 32'(disp), 32'h5958);
    align();
    adj = 1'b0;
    do_cycle();
    run_rises(4, 1'b0);
    check("wrap_5959", 32'(disp), 32'h5959);
    run_rises(4, 1'b0);
    check("wrap_0000", 32'(disp), 32'h0000);

    adj_to(1'b0, 58);
    adj_to(1'b1, 30);
    align();
    sel = 1'b0;
    pause_btn = 1'b1;
    do_cycle();
    pause_btn = 1'b0;
    check("adjmin_paused", 32'(running), 32'd0);
    run_rises(4, 1'b0);
    check("adjmin_disp", 32'(disp), 32'h0030);
    check("adjmin_running", 32'(running), 32'd0);

    adj_to(1'b0, 12);
    adj_to(1'b1, 34);
    align();
    adj = 1'b0;
    pause_btn = 1'b1;
    do_cycle();
    pause_btn = 1'b0;
    run_rises(3, 1'b0);
    check("pre3_disp", 32'(disp), 32'h1234);
    pulse_rst();
    check("midrst_disp", 32'(disp), 32'h0000);
    check("midrst_running", 32'(running), 32'd1);
    run_rises(3, 1'b0);
    check("midrst_3rises", 32'(disp), 32'h0000);
    run_rises(1, 1'b0);
    check("midrst_4rises", 32'(disp), 32'h0001);

    for (int i = 0; i < 6000; i++) begin
      rand_tick = (i >= 3000);
      rst       = ($urandom_range(0, 399) == 0);
      pause_btn = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 149) == 0) adj = !adj;
      if ($urandom_range(0, 49) == 0) sel = 1'($urandom_range(0, 1));
      do_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
